sobel_result_writer: RTL

//  Write-side counterpart of the sobel read scheduler. Takes the filter's per-pixel
//  8-bit result stream, packs 8 pixels into one 64-bit word and issues single-cycle

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_result_writer_if.sv | 42 ++++
 rtl/sobel_word_packer.sv | 59 +++++
 rtl/sobel_result_writer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel result writer.
// Holds the FSM state encoding, pixel/word geometry and default address geometry.
// Optional feature macro used by the files that import this package:
//   SOBEL_WRITER_THRESH_EN  (binary thresholding of accepted pixels)
package sobel_pkg;

  localparam int unsigned PIX_W         = 8;
  localparam int unsigned PIX_PER_WORD  = 8;
  localparam int unsigned WORD_W        = PIX_W * PIX_PER_WORD;
  localparam int unsigned LANE_W        = $clog2(PIX_PER_WORD);
  localparam int unsigned DEF_ADDR_W        = 20;
  localparam int unsigned DEF_WORDS_PER_ROW = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DONE = 2'd2
  } writer_state_t;

endpackage

// File: rtl/sobel_result_writer_if.sv
// Pixel-stream / SRAM-write bundle of the sobel result writer.
// Signals:
//   startEn, pix_valid, pix_data, flush, (thresh)  : source -> writer
//   pix_ready, we, write_addr, data, done          : writer -> source / SRAM
// Modports: master = pixel source / SRAM side, slave = the writer.
// thresh exists only when SOBEL_WRITER_THRESH_EN is defined.
interface sobel_result_writer_if
  import sobel_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic              startEn;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic              flush;
  logic              we;
  logic [ADDR_W-1:0] write_addr;
  logic [WORD_W-1:0] data;
  logic              done;
`ifdef SOBEL_WRITER_THRESH_EN
  logic [PIX_W-1:0]  thresh;
`endif

  modport master (
`ifdef SOBEL_WRITER_THRESH_EN
    output thresh,
`endif
    output startEn, pix_valid, pix_data, flush,
    input  pix_ready, we, write_addr, data, done
  );

  modport slave (
`ifdef SOBEL_WRITER_THRESH_EN
    input  thresh,
`endif
    input  startEn, pix_valid, pix_data, flush,
    output pix_ready, we, write_addr, data, done
  );

endinterface

// File: rtl/sobel_word_packer.sv
// Packs accepted 8-bit pixels into 64-bit words, lane 0 first.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   accept       : a pixel is transferred this cycle
//   pix          : pixel value to store
//   flush        : emit a partial word (zero padded) if any lane is filled
//   emit_c       : combinational, a word is being completed this cycle
//   word_valid   : registered, word holds a new packed word (one cycle)
//   word         : last packed word, held between emissions
module sobel_word_packer
  import sobel_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              accept,
  input  logic [PIX_W-1:0]  pix,
  input  logic              flush,
  output logic              emit_c,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [LANE_W-1:0] cnt;
  logic [WORD_W-1:0] lanes;
  logic [WORD_W-1:0] lanes_ins_c;
  logic              full_c;

  // Insert the current pixel into its lane; unfilled lanes stay zero.
  always_comb begin
    lanes_ins_c = lanes;
    if (accept) begin
      lanes_ins_c[{cnt, 3'b000} +: PIX_W] = pix;
    end
  end

  // A flush together with the 8th accept yields just the full word.
  assign full_c = accept && (cnt == LANE_W'(PIX_PER_WORD - 1));
  assign emit_c = full_c || (flush && ((cnt != '0) || accept));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      lanes      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= emit_c;
      if (emit_c) begin
        word  <= lanes_ins_c;
        lanes <= '0;
        cnt   <= '0;
      end else if (accept) begin
        lanes <= lanes_ins_c;
        cnt   <= cnt + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_result_writer.sv
// Sobel result writer: packs the filter's pixel stream into 64-bit words and
// writes them row by row into the output SRAM, pulsing done with the last word.
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high reset
//   bus    : sobel_result_writer_if.slave (pixel stream in, SRAM write out)
// Optional: SOBEL_WRITER_THRESH_EN stores each pixel as FF/00 against bus.thresh.
module sobel_result_writer
  import sobel_pkg::*;
#(
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned BASE_ADDR     = 768,
  parameter int unsigned WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int unsigned ROW_STRIDE    = 256,
  parameter int unsigned NUM_ROWS      = 256
) (
  input  logic clk,
  input  logic reset,
  sobel_result_writer_if.slave bus
);

  localparam int unsigned COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  writer_state_t     state, state_n;
  logic [COL_W-1:0]  col, col_n;
  logic [ROW_W-1:0]  row, row_n;
  logic [ADDR_W-1:0] row_base, row_base_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              done_q, done_n;
  logic              ready_q, ready_n;

  logic              accept_c;
  logic              flush_c;
  logic              emit_c;
  logic [PIX_W-1:0]  pix_store_c;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  // ready is only ever high in PACK, so it also gates pixels in IDLE/DONE.
  assign accept_c = bus.pix_valid && ready_q;
  assign flush_c  = bus.flush && (state == ST_PACK);

`ifdef SOBEL_WRITER_THRESH_EN
  assign pix_store_c = (bus.pix_data >= bus.thresh) ? 8'hFF : 8'h00;
`else
  assign pix_store_c = bus.pix_data;
`endif

  sobel_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept_c),
    .pix        (pix_store_c),
    .flush      (flush_c),
    .emit_c     (emit_c),
    .word_valid (word_valid),
    .word       (word)
  );

  // Next state, address generation and registered output values.
  always_comb begin
    state_n    = state;
    col_n      = col;
    row_n      = row;
    row_base_n = row_base;
    addr_n     = addr_q;
    done_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.startEn) begin
          state_n    = ST_PACK;
          col_n      = '0;
          row_n      = '0;
          row_base_n = ADDR_W'(BASE_ADDR);
        end
      end
      ST_PACK: begin
        if (emit_c) begin
          addr_n = row_base + ADDR_W'(col);
          if (col == COL_W'(WORDS_PER_ROW - 1)) begin
            col_n      = '0;
            row_n      = row + ROW_W'(1);
            row_base_n = row_base + ADDR_W'(ROW_STRIDE);
            if (row == ROW_W'(NUM_ROWS - 1)) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end
          end else begin
            col_n = col + COL_W'(1);
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    ready_n = (state_n == ST_PACK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      row      <= row_n;
      row_base <= row_base_n;
      addr_q   <= addr_n;
      done_q   <= done_n;
      ready_q  <= ready_n;
    end
  end

  assign bus.we         = word_valid;
  assign bus.data       = word;
  assign bus.write_addr = addr_q;
  assign bus.done       = done_q;
  assign bus.pix_ready  = ready_q;

endmodule
